// File: rtl/cache_pkg.sv
// cache_pkg: replacement policy selector and LFSR constants shared by the cache blocks
package cache_pkg;
  typedef enum logic [1:0] {REPL_LRU, REPL_FIFO, REPL_RANDOM} replace_policy_e;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Fibonacci taps 16,14,13,11 as a mask over state bits 15,13,12,10
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
endpackage

// File: rtl/lfsr16.sv
// lfsr16: free-running 16-bit Fibonacci LFSR, seeded on reset
module lfsr16 import cache_pkg::*; (
  input  logic        clk_i,
  input  logic        rst_ni,
  output logic [15:0] state_o
);
  logic [15:0] state_q;
  always_ff @(posedge clk_i)
    state_q <= !rst_ni ? LFSR_SEED : {state_q[14:0], ^(state_q & LFSR_TAPS)};
  assign state_o = state_q;
endmodule

// File: rtl/replace_policy_unit.sv
// replace_policy_unit: per-set victim selection (LRU, FIFO or pseudo-random) preferring invalid ways
module replace_policy_unit import cache_pkg::*; #(
  parameter int              SET_SIZE = 4,
  parameter int              SET_NUM  = 16,
  parameter replace_policy_e POLICY   = REPL_LRU,
  localparam int             IDX_W    = $clog2(SET_NUM),
  localparam int             AGE_W    = $clog2(SET_SIZE)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                req_i,
  input  logic [IDX_W-1:0]    req_set_i,
  input  logic [SET_SIZE-1:0] valid_lines_i,
  output logic                victim_valid_o,
  output logic [SET_SIZE-1:0] victim_line_o,
  input  logic                upd_i,
  input  logic [IDX_W-1:0]    upd_set_i,
  input  logic [SET_SIZE-1:0] upd_line_i,
  input  logic                upd_fill_i
);
  typedef logic [SET_SIZE-1:0][AGE_W-1:0] ages_t;
  function automatic logic [AGE_W-1:0] low_idx(logic [SET_SIZE-1:0] v);
    logic [AGE_W-1:0] r;
    r = '0;
    for (int i = SET_SIZE - 1; i >= 0; i--) if (v[i]) r = AGE_W'(i);
    return r;
  endfunction
  // Accessed way becomes youngest; only ways younger than it age by one
  function automatic ages_t lru_next(ages_t a, logic [SET_SIZE-1:0] line);
    ages_t n;
    logic [AGE_W-1:0] w;
    n = a;
    w = low_idx(line);
    for (int i = 0; i < SET_SIZE; i++) if (a[i] < a[w]) n[i] = a[i] + AGE_W'(1);
    n[w] = '0;
    return |line ? n : a;
  endfunction
  logic [AGE_W-1:0] pol_idx, vic_idx;
  logic fwd;
  logic victim_valid_q;
  logic [SET_SIZE-1:0] victim_line_q;
  if (SET_SIZE < 2 || SET_SIZE > 16 || (SET_SIZE & (SET_SIZE - 1)) != 0) begin : g_bad_size
    $error("SET_SIZE must be a power of two in 2..16");
  end
  if (SET_NUM < 2 || (SET_NUM & (SET_NUM - 1)) != 0) begin : g_bad_num
    $error("SET_NUM must be a power of two >= 2");
  end
  assign fwd = upd_i && upd_set_i == req_set_i;
  if (POLICY == REPL_LRU) begin : g_lru
    ages_t ages_q [SET_NUM];
    ages_t ages_d, req_ages;
    logic unused_fill;
    assign ages_d   = lru_next(ages_q[upd_set_i], upd_line_i);
    assign req_ages = fwd ? ages_d : ages_q[req_set_i];
    always_comb begin
      pol_idx = '0;
      for (int i = 0; i < SET_SIZE; i++) if (req_ages[i] == AGE_W'(SET_SIZE - 1)) pol_idx = AGE_W'(i);
    end
    always_ff @(posedge clk_i)
      if (!rst_ni) begin
        for (int s = 0; s < SET_NUM; s++)
          for (int i = 0; i < SET_SIZE; i++) ages_q[s][i] <= AGE_W'(SET_SIZE - 1 - i);
      end else if (upd_i) ages_q[upd_set_i] <= ages_d;
    assign unused_fill = upd_fill_i;
  end else if (POLICY == REPL_FIFO) begin : g_fifo
    logic [AGE_W-1:0] ptr_q [SET_NUM];
    logic [AGE_W-1:0] ptr_d;
    assign ptr_d   = ptr_q[upd_set_i] + AGE_W'(upd_fill_i && |upd_line_i);
    assign pol_idx = fwd ? ptr_d : ptr_q[req_set_i];
    always_ff @(posedge clk_i)
      if (!rst_ni) begin
        for (int s = 0; s < SET_NUM; s++) ptr_q[s] <= '0;
      end else if (upd_i) ptr_q[upd_set_i] <= ptr_d;
  end else begin : g_rnd
    logic [15:0] lfsr;
    logic unused_upd;
    lfsr16 u_lfsr (.clk_i(clk_i), .rst_ni(rst_ni), .state_o(lfsr));
    assign pol_idx    = AGE_W'(lfsr % SET_SIZE);
    assign unused_upd = ^{upd_i, upd_set_i, upd_line_i, upd_fill_i, fwd};
  end
  assign vic_idx = &valid_lines_i ? pol_idx : low_idx(~valid_lines_i);
  always_ff @(posedge clk_i)
    if (!rst_ni) begin
      victim_valid_q <= 1'b0;
      victim_line_q  <= '0;
    end else begin
      victim_valid_q <= req_i;
      if (req_i) victim_line_q <= SET_SIZE'(1) << vic_idx;
    end
  assign victim_valid_o = victim_valid_q;
  assign victim_line_o  = victim_line_q;
endmodule

// File: tb/tb_replace_policy_unit.sv
// tb_replace_policy_unit: LRU, FIFO and RANDOM instances driven alike, checked by a queue scoreboard
module tb_replace_policy_unit;
  import cache_pkg::*;
  localparam int SS = 4, SN = 16;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n = 1'b0, req = 1'b0, upd = 1'b0, fill = 1'b0;
  logic [3:0] rset = '0, uset = '0, vl = 4'hF, uline = '0;
  logic [2:0] dv;
  logic [2:0][3:0] dl;
  replace_policy_unit #(.SET_SIZE(SS), .SET_NUM(SN), .POLICY(REPL_LRU)) u_lru (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .req_set_i(rset), .valid_lines_i(vl),
    .victim_valid_o(dv[0]), .victim_line_o(dl[0]), .upd_i(upd), .upd_set_i(uset),
    .upd_line_i(uline), .upd_fill_i(fill));
  replace_policy_unit #(.SET_SIZE(SS), .SET_NUM(SN), .POLICY(REPL_FIFO)) u_fifo (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .req_set_i(rset), .valid_lines_i(vl),
    .victim_valid_o(dv[1]), .victim_line_o(dl[1]), .upd_i(upd), .upd_set_i(uset),
    .upd_line_i(uline), .upd_fill_i(fill));
  replace_policy_unit #(.SET_SIZE(SS), .SET_NUM(SN), .POLICY(REPL_RANDOM)) u_rnd (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .req_set_i(rset), .valid_lines_i(vl),
    .victim_valid_o(dv[2]), .victim_line_o(dl[2]), .upd_i(upd), .upd_set_i(uset),
    .upd_line_i(uline), .upd_fill_i(fill));
  typedef struct packed {logic [2:0] v; logic [2:0][3:0] l; logic cnt;} exp_t;
  exp_t q[$];
  exp_t pend;
  bit have_pend = 0, counting = 0;
  int n_chk = 0, n_fail = 0;
  int cnt[4] = '{0, 0, 0, 0};
  string nm[3] = '{"lru", "fifo", "rnd"};
  int lru_ord[SN][$];
  int fills[SN];
  logic [15:0] lf;
  logic [2:0][3:0] last_l;
  function automatic void chk(string n, logic [3:0] a, logic [3:0] x);
    n_chk++;
    if (a !== x) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", n, a, x);
    end
  endfunction
  function automatic int low(logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return -1;
  endfunction
  // Reference: LRU as a recency list (front = most recent), FIFO as a fill count
  task automatic model_reset();
    for (int s = 0; s < SN; s++) begin
      lru_ord[s] = {};
      for (int w = SS - 1; w >= 0; w--) lru_ord[s].push_back(w);
      fills[s] = 0;
    end
    lf = 16'hACE1;
    last_l = '0;
  endtask
  task automatic cyc(logic r, logic rq, int rs, logic [3:0] v, logic u, int us, logic [3:0] ul, logic f);
    exp_t e;
    int w, inv;
    @(posedge clk);
    if (have_pend) q.push_back(pend);
    #1;
    rst_n = r; req = rq; rset = 4'(rs); vl = v; upd = u; uset = 4'(us); uline = ul; fill = f;
    e = '0;
    e.cnt = counting;
    if (!r) model_reset();
    else begin
      w = low(ul);
      if (u && w >= 0) begin
        for (int i = 0; i < lru_ord[us].size(); i++)
          if (lru_ord[us][i] == w) begin
            lru_ord[us].delete(i);
            break;
          end
        lru_ord[us].push_front(w);
        if (f) fills[us]++;
      end
      if (rq) begin
        inv = low(~v);
        e.v = 3'b111;
        last_l[0] = 4'b0001 << (inv >= 0 ? inv : lru_ord[rs][$]);
        last_l[1] = 4'b0001 << (inv >= 0 ? inv : fills[rs] % SS);
        last_l[2] = 4'b0001 << (inv >= 0 ? inv : int'(lf[1:0]));
      end
      lf = {lf[14:0], lf[15] ^ lf[13] ^ lf[12] ^ lf[10]};
    end
    e.l = last_l;
    pend = e;
    have_pend = 1;
  endtask
  task automatic idle();
    cyc(1, 0, 0, 4'hF, 0, 0, 4'h0, 0);
  endtask
  task automatic rnd_cyc(logic r, bit all_valid);
    cyc(r, 1'($urandom_range(0, 3) != 0), $urandom_range(0, SN - 1),
        (all_valid || $urandom_range(0, 1) == 1) ? 4'hF : 4'($urandom_range(0, 15)),
        1'($urandom_range(0, 1)), $urandom_range(0, SN - 1), 4'($urandom_range(0, 15)),
        1'($urandom_range(0, 1)));
  endtask
  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      for (int k = 0; k < 3; k++) begin
        chk({nm[k], "_valid"}, {3'b000, dv[k]}, {3'b000, e.v[k]});
        chk({nm[k], "_line"}, dl[k], e.l[k]);
      end
      if (e.cnt && dv[2]) for (int w = 0; w < 4; w++) if (dl[2][w]) cnt[w]++;
    end
  end
  initial begin
    int tot;
    model_reset();
    repeat (3) cyc(0, 0, 0, 4'hF, 0, 0, 4'h0, 0);
    cyc(1, 1, 3, 4'hF, 0, 0, 4'h0, 0);
    idle();
    idle();
    for (int w = 0; w < 4; w++) cyc(1, 0, 0, 4'hF, 1, 5, 4'b0001 << w, 0);
    cyc(1, 1, 5, 4'hF, 0, 0, 4'h0, 0);
    cyc(1, 0, 0, 4'hF, 1, 5, 4'b0001, 0);
    cyc(1, 1, 5, 4'hF, 0, 0, 4'h0, 0);
    cyc(1, 1, 6, 4'hF, 0, 0, 4'h0, 0);
    repeat (3) cyc(1, 0, 0, 4'hF, 1, 2, 4'b0010, 1);
    repeat (2) cyc(1, 0, 0, 4'hF, 1, 2, 4'b0100, 0);
    cyc(1, 1, 2, 4'hF, 0, 0, 4'h0, 0);
    cyc(1, 0, 0, 4'hF, 1, 2, 4'b1000, 1);
    cyc(1, 1, 2, 4'hF, 0, 0, 4'h0, 0);
    cyc(1, 1, 7, 4'b1011, 0, 0, 4'h0, 0);
    cyc(1, 1, 1, 4'hF, 1, 1, 4'b0001, 0);
    cyc(1, 1, 9, 4'hF, 1, 9, 4'b0110, 1);
    cyc(1, 1, 9, 4'hF, 1, 9, 4'b0000, 1);
    idle();
    counting = 1;
    repeat (1000)
      cyc(1, 1, $urandom_range(0, SN - 1), 4'hF, 1'($urandom_range(0, 1)), $urandom_range(0, SN - 1),
          4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
    counting = 0;
    repeat (2) cyc(0, 1, 4, 4'hF, 1, 4, 4'b0001, 1);
    repeat (50) cyc(1, 1, $urandom_range(0, SN - 1), 4'hF, 0, 0, 4'h0, 0);
    repeat (800) rnd_cyc(1'($urandom_range(0, 99) != 0), 1'b0);
    @(posedge clk);
    if (have_pend) q.push_back(pend);
    have_pend = 0;
    repeat (3) @(negedge clk);
    tot = 0;
    for (int w = 0; w < 4; w++) begin
      n_chk++;
      tot += cnt[w];
      if (cnt[w] < 200 || cnt[w] > 300) begin
        n_fail++;
        $display("FAIL rnd_dist way%0d: got %0d picks required 200..300", w, cnt[w]);
      end
    end
    n_chk++;
    if (tot != 1000) begin
      n_fail++;
      $display("FAIL rnd_count: got %0d victims required 1000", tot);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/replace_policy_unit.md
# replace_policy_unit

Per-set victim selection for the set-associative cache. It tracks replacement state for every set, not one shared set. The policy is selectable at elaboration: true LRU, FIFO or pseudo-random. Invalid ways are preferred over the policy choice, and victims are returned one cycle after a registered request. It sits beside the tag array: the cache controller issues a victim request on a miss and reports every hit and fill back as an update.

## Interface
- SET_SIZE, 4, ways per set; power of two, 2..16
- SET_NUM, 16, number of sets; power of two, ≥2
- POLICY, REPL_LRU, replacement policy: REPL_LRU, REPL_FIFO or REPL_RANDOM
- IDX_W, $clog2(SET_NUM), set index width (derived)
- AGE_W, $clog2(SET_SIZE), per-way age / pointer width (derived)

Ports:
- clk_i  in  1  clock; all state changes on its rising edge
- rst_ni  in  1  synchronous, active-low reset
- req_i  in  1  victim request valid
- req_set_i  in  IDX_W  set index of request
- valid_lines_i  in  SET_SIZE  valid bits of the requested set, from tag array
- victim_valid_o  out  1  victim result valid, one cycle after req_i
- victim_line_o  out  SET_SIZE  one-hot victim way
- upd_i  in  1  access update valid
- upd_set_i  in  IDX_W  set being updated
- upd_line_i  in  SET_SIZE  one-hot way accessed
- upd_fill_i  in  1  1 = fill (line allocated), 0 = hit

## Operation
- LRU state per set: SET_SIZE ages of AGE_W bits, always a permutation of 0..SET_SIZE-1. The oldest way has the maximum age.
  - Update to way w with old age a: age[w]←0; every way with age < a increments; the others are unchanged.
  - Hits and fills both update.
- FIFO state per set: one AGE_W-bit pointer.
  - Victim = way[pointer].
  - A fill increments the pointer modulo SET_SIZE; hits are ignored.
- RANDOM: one free-running 16-bit Fibonacci LFSR, taps 16,14,13,11, advancing every cycle out of reset.
  - Victim = way[lfsr[AGE_W-1:0]].
  - Updates are ignored.
- Invalid preference: if valid_lines_i has any 0 bit, the victim is the lowest-index invalid way, whatever the policy.
- upd_line_i = 0: update ignored. Multi-hot: the lowest set bit is used.
- A request does not change state; only updates do (plus the LFSR step).
- Same-cycle upd_i and req_i to the same set: the victim is computed from the post-update state (forwarded). Different sets: independent.
- Reset values:
  - LRU age[w] = SET_SIZE-1-w, so way 0 is victim.
  - FIFO pointer = 0.
  - LFSR = 16'hACE1.
  - victim_valid_o = 0; victim_line_o = 0.

## Timing
- Request in cycle N → victim_valid_o=1 and victim_line_o valid in cycle N+1 only (single-cycle pulse per request).
- Back-to-back requests are accepted every cycle; there is no stall and no ready signal.
- Update in cycle N → state visible to requests sampled in cycle N (forwarding) and later.
- valid_lines_i is sampled in the request cycle, together with req_set_i.
- Reset asserted mid-operation: on the next edge all state returns to reset values and victim_valid_o=0, even if req_i was high the cycle before. req_i or upd_i during reset are dropped.
- victim_line_o holds its last value when victim_valid_o=0. It is exactly one-hot whenever victim_valid_o=1.

## Structure
- cache_pkg holds:
  - typedef enum replace_policy_e {REPL_LRU, REPL_FIFO, REPL_RANDOM}
  - LFSR seed and tap constants
- Sub-module lfsr16 (clk_i, rst_ni, state_o) is instantiated only when POLICY==REPL_RANDOM.
- LRU/FIFO state is a register array indexed by set. The next-state function is a combinational helper shared by the update path and the forwarding path.
- Elaboration assertions: power-of-two SET_SIZE and SET_NUM.

## Test plan
- Reset then req set 3, all valid, LRU → cycle later victim_line_o=4'b0001, victim_valid_o=1; next cycle victim_valid_o=0.
- LRU, set 5, all valid: updates to ways 0,1,2,3 in order → victim way 0. Then hit way 0 → victim way 1. Set 6 is still victim way 0.
- FIFO, set 2: 3 fills, then 2 hits → victim way 3. One more fill → pointer wraps after way 3, victim way 0.
- valid_lines_i=4'b1011 on request, any policy → victim 4'b0100 regardless of ages.
- Same cycle: upd_i to set 1 way 0 and req_i to set 1 (LRU, reset state) → victim way 1, not way 0.
- RANDOM: 1000 requests, all valid → victims match a reference LFSR model seeded 16'hACE1. Each way is chosen 200–300 times. Reset asserted mid-stream restarts the sequence.
